// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with per-register scoreboard.
// One write port, two combinational read ports, optional zero reg and bypass.
module reg_file_sb #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                                   Clock,
  input  logic                                   Reset_n,
  input  logic [ADDR_WIDTH-1:0]                  A,
  input  logic [ADDR_WIDTH-1:0]                  B,
  output logic [DATA_WIDTH-1:0]                  Output_A,
  output logic [DATA_WIDTH-1:0]                  Output_B,
  output logic                                   Valid_A,
  output logic                                   Valid_B,
  input  logic                                   w,
  input  logic [ADDR_WIDTH-1:0]                  to,
  input  logic [DATA_WIDTH-1:0]                  data,
  input  logic                                   Reserve,
  input  logic [ADDR_WIDTH-1:0]                  ReserveAddr,
  output logic                                   Conflict,
  output logic [ADDR_WIDTH:0]                    PendingCount,
  output logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]  r_flat
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CW       = ADDR_WIDTH + 1;
  localparam bit ZR       = (ZERO_REG != 0);
  localparam bit BP       = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pend;
  logic                  r_conflict;
  logic [CW-1:0]         r_count;

  logic                  w_we;
  logic                  w_re;
  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_pend_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_conflict_nxt;

  // Qualify write/reserve so register 0 is untouchable when hardwired.
  always_comb begin
    w_we = w & ~(ZR & (to == '0));
    w_re = Reserve & ~(ZR & (ReserveAddr == '0));
  end

  // Next pending vector: a write retires, a reservation sets (set wins).
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_clr[i] = w_we & (to == ADDR_WIDTH'(i));
      w_set[i] = w_re & (ReserveAddr == ADDR_WIDTH'(i));
    end
    w_pend_nxt = (r_pend & ~w_clr) | w_set;
  end

  // Popcount of the next pending vector, registered as PendingCount.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_count_nxt = w_count_nxt + CW'(w_pend_nxt[i]);
    end
  end

  // Re-reserving a busy register that is not retired this cycle is a WAW hit.
  always_comb begin
    w_conflict_nxt = w_re & r_pend[ReserveAddr]
                   & ~(w_we & (to == ReserveAddr));
  end

  // Register array storage.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[to] <= data;
    end
  end

  // Scoreboard state, conflict pulse and pending count.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend     <= '0;
      r_conflict <= 1'b0;
      r_count    <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_conflict <= w_conflict_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Read port A: zero reg, then bypass, then stored value and scoreboard.
  always_comb begin
    Output_A = r_regs[A];
    Valid_A  = ~r_pend[A];
    if (ZR && (A == '0)) begin
      Output_A = '0;
      Valid_A  = 1'b1;
    end else if (BP && w_we && (to == A)) begin
      Output_A = data;
      Valid_A  = 1'b1;
    end
  end

  // Read port B: same rules as port A.
  always_comb begin
    Output_B = r_regs[B];
    Valid_B  = ~r_pend[B];
    if (ZR && (B == '0)) begin
      Output_B = '0;
      Valid_B  = 1'b1;
    end else if (BP && w_we && (to == B)) begin
      Output_B = data;
      Valid_B  = 1'b1;
    end
  end

  assign Conflict     = r_conflict;
  assign PendingCount = r_count;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign r_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule
